// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
//   uart_state_e    : serialiser FSM states
//   UART_DATA_BITS  : payload bits per frame
//   UART_IDLE_LEVEL : line level between frames (also the stop-bit level)
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering bytes in front of the UART serialiser.
//   clk_i, arst_i : clock, asynchronous active-high reset (clears pointers)
//   push_i/wdata_i: write request and data; ignored while full_o
//   pop_i/rdata_o : read request; rdata_o always shows the head entry
//   full_o/empty_o: occupancy flags, derived from registered pointers only
//   count_o       : current occupancy, 0..DEPTH
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter, 8 data bits, no parity, 1 or 2 stop bits, LSB first.
//   clk_i, arst_i  : clock, asynchronous active-high reset
//   data_i, valid_i: byte source; accepted on a rising edge when ready_o is high
//   ready_o        : FIFO not full (independent of valid_i)
//   tx_o           : registered serial line, idle high
//   busy_o         : frame in progress or bytes still queued
//   fifo_cnt_o     : FIFO occupancy
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  // Wide enough for the merged stop period, up to 2 * 65535 cycles.
  localparam int unsigned     CntW     = 17;
  localparam logic [CntW-1:0] BitLoad  = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] StopLoad = CntW'(STOP_BITS * BAUD_DIV - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [2:0]      LastBit  = 3'(UART_DATA_BITS - 1);

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic            fifo_full, fifo_empty, fifo_pop;
  logic [7:0]      fifo_head;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .push_i  (valid_i),
    .wdata_i (data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt_o)
  );

  assign ready_o = !fifo_full;
  assign tx_o    = tx_q;
  assign busy_o  = (state_q != StIdle) || !fifo_empty;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = UART_IDLE_LEVEL;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          tx_d     = ~UART_IDLE_LEVEL;
          baud_d   = BitLoad;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_q == '0) begin
          state_d = StData;
          idx_d   = '0;
          tx_d    = shift_q[0];
          baud_d  = BitLoad;
        end else begin
          baud_d = baud_q - CntOne;
        end
      end
      StData: begin
        if (baud_q == '0) begin
          if (idx_q == LastBit) begin
            state_d = StStop;
            tx_d    = UART_IDLE_LEVEL;
            baud_d  = StopLoad;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            idx_d   = idx_q + 3'd1;
            baud_d  = BitLoad;
          end
        end else begin
          baud_d = baud_q - CntOne;
        end
      end
      StStop: begin
        if (baud_q == '0) begin
          // Chain straight into the next start bit so queued frames have no gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            tx_d     = ~UART_IDLE_LEVEL;
            baud_d   = BitLoad;
            state_d  = StStart;
          end else begin
            tx_d    = UART_IDLE_LEVEL;
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= StIdle;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule
